// File: rtl/freq_sel_ctrl_if.sv
// ---------------------------------------------------------------------------
// freq_sel_ctrl_if
// Groups the user-facing button pulses and the status/clock outputs of the
// frequency select controller.
//   master : drives btn_up / btn_down / run_toggle, observes the outputs
//   slave  : the controller itself
// Signals:
//   btn_up, btn_down, run_toggle : one-cycle request pulses (already debounced)
//   clko    : divided square wave
//   tick    : one-cycle pulse in the cycle clko becomes 1
//   sel     : rate applied to the divider (2^sel Hz at default parameters)
//   pending : requested rate differs from the applied rate
//   running : controller is in RUN
// ---------------------------------------------------------------------------
interface freq_sel_ctrl_if;
  logic       btn_up;
  logic       btn_down;
  logic       run_toggle;
  logic       clko;
  logic       tick;
  logic [2:0] sel;
  logic       pending;
  logic       running;

  modport master (
    output btn_up, btn_down, run_toggle,
    input  clko, tick, sel, pending, running
  );

  modport slave (
    input  btn_up, btn_down, run_toggle,
    output clko, tick, sel, pending, running
  );
endinterface

// File: rtl/freq_sel_ctrl.sv
// ---------------------------------------------------------------------------
// freq_sel_ctrl
// Button-driven rate controller with a glitch-free programmable divider.
// Button pulses move a requested rate (tgt) between 0 and 7; the applied rate
// (sel) only follows it at a half-period boundary while running, so clko never
// produces a shortened half-period. While stopped the waveform is frozen and a
// new rate is loaded immediately with the divider count cleared.
// Parameters:
//   BASE_HALF : half-period in clk_in cycles at sel=0 (>= 128)
//   CW        : divider counter width, must hold BASE_HALF-1
// Ports:
//   clk_in : system clock
//   rst    : synchronous active-high reset
//   bus    : freq_sel_ctrl_if slave (buttons in, clko/tick/sel/pending/running out)
// ---------------------------------------------------------------------------
module freq_sel_ctrl #(
  parameter int BASE_HALF = 50_000_000,
  parameter int CW        = 28
) (
  input  logic            clk_in,
  input  logic            rst,
  freq_sel_ctrl_if.slave  bus
);

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_STOP = 1'b1
  } state_t;

  localparam logic [CW-1:0] BASE_W = CW'(BASE_HALF);

  state_t        state_reg, state_next;
  logic [2:0]    tgt_reg, tgt_next;
  logic [2:0]    sel_reg, sel_next;
  logic [CW-1:0] count_reg, count_next;
  logic          clko_reg, clko_next;
  logic          tick_reg, tick_next;

  logic          pending;
  logic          boundary;
  logic [CW-1:0] term;
  logic [CW-1:0] term_table [8];

  // Terminal counts are constants per rate, so the divider only needs a mux
  // rather than a barrel shifter and subtractor.
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_term
      localparam logic [CW-1:0] TERM_VAL = (BASE_W >> gi) - CW'(1);
      assign term_table[gi] = TERM_VAL;
    end
  endgenerate

  assign term     = term_table[sel_reg];
  // >= rather than == keeps the divider safe should count ever exceed term.
  assign boundary = (count_reg >= term);
  assign pending  = (tgt_reg != sel_reg);

  // Requested rate: saturating up/down, simultaneous pulses cancel.
  always_comb begin
    tgt_next = tgt_reg;
    if (bus.btn_up && !bus.btn_down) begin
      if (tgt_reg != 3'd7) tgt_next = tgt_reg + 3'd1;
    end else if (bus.btn_down && !bus.btn_up) begin
      if (tgt_reg != 3'd0) tgt_next = tgt_reg - 3'd1;
    end
  end

  // Run/stop FSM with divider datapath. The behaviour of the current state
  // completes in the cycle of run_toggle; the new state applies next cycle.
  always_comb begin
    state_next = state_reg;
    sel_next   = sel_reg;
    count_next = count_reg;
    clko_next  = clko_reg;
    tick_next  = 1'b0;
    case (state_reg)
      ST_RUN: begin
        if (boundary) begin
          count_next = '0;
          clko_next  = ~clko_reg;
          tick_next  = ~clko_reg;
          // Rate switches only here, so both half-periods around the switch
          // are full length.
          if (pending) sel_next = tgt_reg;
        end else begin
          count_next = count_reg + CW'(1);
        end
        if (bus.run_toggle) state_next = ST_STOP;
      end
      ST_STOP: begin
        // Output is frozen, so the rate can be applied at once; clearing the
        // count gives a full new half-period on resume.
        if (pending) begin
          sel_next   = tgt_reg;
          count_next = '0;
        end
        if (bus.run_toggle) state_next = ST_RUN;
      end
      default: state_next = ST_RUN;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      state_reg <= ST_RUN;
      tgt_reg   <= 3'd0;
      sel_reg   <= 3'd0;
      count_reg <= '0;
      clko_reg  <= 1'b0;
      tick_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      tgt_reg   <= tgt_next;
      sel_reg   <= sel_next;
      count_reg <= count_next;
      clko_reg  <= clko_next;
      tick_reg  <= tick_next;
    end
  end

  assign bus.clko    = clko_reg;
  assign bus.tick    = tick_reg;
  assign bus.sel     = sel_reg;
  assign bus.pending = pending;
  assign bus.running = (state_reg == ST_RUN);

endmodule
